// File: rtl/seq_packet_arbiter_pkg.sv
// Shared sequence-packet geometry and arbiter types for the packet arbiter
// and its rotating picker.
package seq_packet_arbiter_pkg;

    localparam int SEQ_PACKET_SIZE = 4;
    localparam int SEQ_LL_BITS     = 8;
    localparam int SEQ_ML_BITS     = 8;
    localparam int SEQ_OFFSET_BITS = 16;
    localparam int SEQ_ARB_NUM_REQ = 4;

    localparam int SEQ_MASK_W = SEQ_PACKET_SIZE;
    localparam int SEQ_LL_W   = SEQ_PACKET_SIZE * SEQ_LL_BITS;
    localparam int SEQ_ML_W   = SEQ_PACKET_SIZE * SEQ_ML_BITS;
    localparam int SEQ_OFF_W  = SEQ_PACKET_SIZE * SEQ_OFFSET_BITS;

    typedef enum logic {
        S_ARB  = 1'b0,
        S_PASS = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [SEQ_MASK_W-1:0]  mask;
        logic [SEQ_LL_W-1:0]    ll;
        logic [SEQ_ML_W-1:0]    ml;
        logic [SEQ_OFF_W-1:0]   offset;
        logic [SEQ_ML_BITS-1:0] overlap;
        logic                   eoj;
        logic                   delim;
    } seq_pkt_t;

endpackage

// File: rtl/seq_packet_arbiter_rr_pick.sv
// Rotating first-one finder: returns the first set bit strictly after ptr_i,
// wrapping at N-1, so the last-served requester has lowest priority.
module seq_packet_arbiter_rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   valid_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] id_o,
    output logic           found_o
);

    logic [IDW-1:0] idx;

    always_comb begin
        id_o    = '0;
        found_o = 1'b0;
        idx     = ptr_i;
        for (int k = 0; k < N; k++) begin
            // explicit wrap so non-power-of-two N never visits an unused id
            idx = (idx == IDW'(N - 1)) ? '0 : idx + 1'b1;
            if (!found_o && valid_i[idx]) begin
                found_o = 1'b1;
                id_o    = idx;
            end
        end
    end

endmodule

// File: rtl/seq_packet_arbiter.sv
// Job-granular arbiter: one packer owns the downstream sequence consumer from
// grant until its end-of-job packet is accepted; single registered output.
module seq_packet_arbiter
    import seq_packet_arbiter_pkg::*;
#(
    parameter  int NUM_REQ      = SEQ_ARB_NUM_REQ,
    parameter  bit STRICT_ORDER = 1'b1,
    localparam int IDW          = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   i_valid,
    input  logic [NUM_REQ*SEQ_MASK_W-1:0]        i_mask,
    input  logic [NUM_REQ*SEQ_LL_W-1:0]          i_ll,
    input  logic [NUM_REQ*SEQ_ML_W-1:0]          i_ml,
    input  logic [NUM_REQ*SEQ_OFF_W-1:0]         i_offset,
    input  logic [NUM_REQ*SEQ_ML_BITS-1:0]       i_overlap,
    input  logic [NUM_REQ-1:0]                   i_eoj,
    input  logic [NUM_REQ-1:0]                   i_delim,
    output logic [NUM_REQ-1:0]                   i_ready,
    output logic                                 o_valid,
    output logic [SEQ_MASK_W-1:0]                o_mask,
    output logic [SEQ_LL_W-1:0]                  o_ll,
    output logic [SEQ_ML_W-1:0]                  o_ml,
    output logic [SEQ_OFF_W-1:0]                 o_offset,
    output logic [SEQ_ML_BITS-1:0]               o_overlap,
    output logic                                 o_eoj,
    output logic                                 o_delim,
    output logic [IDW-1:0]                       o_req_id,
    input  logic                                 o_ready
);

    arb_state_e     state_q;
    logic [IDW-1:0] grant_q;
    logic [IDW-1:0] ptr_q;
    logic           o_valid_q;
    seq_pkt_t       out_q;
    logic [IDW-1:0] req_id_q;

    logic           pass_ok;
    logic           accept;
    seq_pkt_t       sel_pkt;
    seq_pkt_t       slice_pkt [NUM_REQ];
    logic [IDW-1:0] pick_id;
    logic           pick_found;

    function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] v);
        return (v == IDW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // o_ready reaches i_ready through this one AND; i_valid never does
    assign pass_ok = (state_q == S_PASS) && (!o_valid_q || o_ready);

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        logic     hit;
        seq_pkt_t raw;

        assign hit = (grant_q == IDW'(r));
        assign raw = '{
            mask:    i_mask   [r*SEQ_MASK_W  +: SEQ_MASK_W],
            ll:      i_ll     [r*SEQ_LL_W    +: SEQ_LL_W],
            ml:      i_ml     [r*SEQ_ML_W    +: SEQ_ML_W],
            offset:  i_offset [r*SEQ_OFF_W   +: SEQ_OFF_W],
            overlap: i_overlap[r*SEQ_ML_BITS +: SEQ_ML_BITS],
            eoj:     i_eoj[r],
            delim:   i_delim[r]
        };
        assign slice_pkt[r] = hit ? raw : '0;
        assign i_ready[r]   = pass_ok && hit;
    end

    always_comb begin
        sel_pkt = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            sel_pkt = seq_pkt_t'(sel_pkt | slice_pkt[r]);
        end
    end

    assign accept = |(i_valid & i_ready);

    if (STRICT_ORDER == 1'b0) begin : g_rr
        seq_packet_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
            .valid_i (i_valid),
            .ptr_i   (ptr_q),
            .id_o    (pick_id),
            .found_o (pick_found)
        );
    end else begin : g_fixed
        assign pick_id    = '0;
        assign pick_found = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_ARB;
            grant_q   <= '0;
            ptr_q     <= IDW'(NUM_REQ - 1);
            o_valid_q <= 1'b0;
            out_q     <= '0;
            req_id_q  <= '0;
        end else begin
            case (state_q)
                S_ARB: begin
                    if (STRICT_ORDER) begin
                        grant_q <= inc_id(ptr_q);
                        state_q <= S_PASS;
                    end else if (pick_found) begin
                        grant_q <= pick_id;
                        state_q <= S_PASS;
                    end
                end
                S_PASS: begin
                    // only eoj releases the grant; delim is plain payload
                    if (accept && sel_pkt.eoj) begin
                        ptr_q   <= grant_q;
                        state_q <= S_ARB;
                    end
                end
                default: state_q <= S_ARB;
            endcase

            if (accept) begin
                out_q     <= sel_pkt;
                req_id_q  <= grant_q;
                o_valid_q <= 1'b1;
            end else if (o_ready) begin
                o_valid_q <= 1'b0;
            end
        end
    end

    assign o_valid   = o_valid_q;
    assign o_mask    = out_q.mask;
    assign o_ll      = out_q.ll;
    assign o_ml      = out_q.ml;
    assign o_offset  = out_q.offset;
    assign o_overlap = out_q.overlap;
    assign o_eoj     = out_q.eoj;
    assign o_delim   = out_q.delim;
    assign o_req_id  = req_id_q;

endmodule

// File: tb/tb_seq_packet_arbiter.sv
// Randomized bench: per-requester job queues feed the arbiters and a
// job-order reference model predicts the exact output packet sequence.
module tb_seq_packet_arbiter;
    import seq_packet_arbiter_pkg::*;

    localparam int MW  = SEQ_MASK_W;
    localparam int LLW = SEQ_LL_W;
    localparam int MLW = SEQ_ML_W;
    localparam int OFW = SEQ_OFF_W;
    localparam int OVW = SEQ_ML_BITS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // shared 4-requester stimulus (strict and non-strict instances)
    logic [3:0]       a_valid, a_eoj, a_delim;
    logic [4*MW-1:0]  a_mask;
    logic [4*LLW-1:0] a_ll;
    logic [4*MLW-1:0] a_ml;
    logic [4*OFW-1:0] a_off;
    logic [4*OVW-1:0] a_ovl;
    logic             a_ordy;

    logic [3:0] s_irdy, n_irdy;
    logic s_ov, n_ov, s_eoj, n_eoj, s_dl, n_dl;
    logic [MW-1:0]  s_mask, n_mask;
    logic [LLW-1:0] s_ll, n_ll;
    logic [MLW-1:0] s_ml, n_ml;
    logic [OFW-1:0] s_off, n_off;
    logic [OVW-1:0] s_ovl, n_ovl;
    logic [1:0]     s_id, n_id;

    // 3-requester strict instance
    logic [2:0]       b_valid, b_eoj, b_delim;
    logic [3*MW-1:0]  b_mask;
    logic [3*LLW-1:0] b_ll;
    logic [3*MLW-1:0] b_ml;
    logic [3*OFW-1:0] b_off;
    logic [3*OVW-1:0] b_ovl;
    logic             b_ordy;
    logic [2:0]       c_irdy;
    logic c_ov, c_eoj, c_dl;
    logic [MW-1:0]  c_mask;
    logic [LLW-1:0] c_ll;
    logic [MLW-1:0] c_ml;
    logic [OFW-1:0] c_off;
    logic [OVW-1:0] c_ovl;
    logic [1:0]     c_id;

    seq_packet_arbiter #(.NUM_REQ(4), .STRICT_ORDER(1'b1)) u_s (
        .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .i_mask(a_mask), .i_ll(a_ll),
        .i_ml(a_ml), .i_offset(a_off), .i_overlap(a_ovl), .i_eoj(a_eoj), .i_delim(a_delim),
        .i_ready(s_irdy), .o_valid(s_ov), .o_mask(s_mask), .o_ll(s_ll), .o_ml(s_ml),
        .o_offset(s_off), .o_overlap(s_ovl), .o_eoj(s_eoj), .o_delim(s_dl),
        .o_req_id(s_id), .o_ready(a_ordy));

    seq_packet_arbiter #(.NUM_REQ(4), .STRICT_ORDER(1'b0)) u_n (
        .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .i_mask(a_mask), .i_ll(a_ll),
        .i_ml(a_ml), .i_offset(a_off), .i_overlap(a_ovl), .i_eoj(a_eoj), .i_delim(a_delim),
        .i_ready(n_irdy), .o_valid(n_ov), .o_mask(n_mask), .o_ll(n_ll), .o_ml(n_ml),
        .o_offset(n_off), .o_overlap(n_ovl), .o_eoj(n_eoj), .o_delim(n_dl),
        .o_req_id(n_id), .o_ready(a_ordy));

    seq_packet_arbiter #(.NUM_REQ(3), .STRICT_ORDER(1'b1)) u_3 (
        .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .i_mask(b_mask), .i_ll(b_ll),
        .i_ml(b_ml), .i_offset(b_off), .i_overlap(b_ovl), .i_eoj(b_eoj), .i_delim(b_delim),
        .i_ready(c_irdy), .o_valid(c_ov), .o_mask(c_mask), .o_ll(c_ll), .o_ml(c_ml),
        .o_offset(c_off), .o_overlap(c_ovl), .o_eoj(c_eoj), .o_delim(c_dl),
        .o_req_id(c_id), .o_ready(b_ordy));

    seq_pkt_t s_pkt, n_pkt, c_pkt, d_pkt;
    assign s_pkt = '{mask:s_mask, ll:s_ll, ml:s_ml, offset:s_off, overlap:s_ovl, eoj:s_eoj, delim:s_dl};
    assign n_pkt = '{mask:n_mask, ll:n_ll, ml:n_ml, offset:n_off, overlap:n_ovl, eoj:n_eoj, delim:n_dl};
    assign c_pkt = '{mask:c_mask, ll:c_ll, ml:c_ml, offset:c_off, overlap:c_ovl, eoj:c_eoj, delim:c_dl};

    // sel picks which 4-requester instance is under test
    logic       sel = 1'b0;
    logic [3:0] d_irdy;
    logic       d_ov;
    logic [1:0] d_id;
    assign d_irdy = sel ? n_irdy : s_irdy;
    assign d_ov   = sel ? n_ov   : s_ov;
    assign d_id   = sel ? n_id   : s_id;
    assign d_pkt  = sel ? n_pkt  : s_pkt;

    typedef struct {
        int       req;
        seq_pkt_t p;
    } exp_t;

    seq_pkt_t srcq [4][$];
    exp_t     expq [$];
    int       xfer_cyc [$];
    bit       xfer_eoj [$];
    bit       watch_r2 = 1'b0;

    function automatic seq_pkt_t rand_pkt(input bit eoj);
        seq_pkt_t p;
        p.mask    = MW'($urandom);
        if ($urandom_range(0, 4) == 0) p.mask = '0;
        p.ll      = LLW'($urandom);
        p.ml      = MLW'($urandom);
        p.offset  = OFW'({$urandom, $urandom});
        p.overlap = OVW'($urandom);
        p.eoj     = eoj;
        p.delim   = 1'($urandom);
        return p;
    endfunction

    task automatic add_job(input int r, input int n);
        for (int i = 0; i < n; i++) srcq[r].push_back(rand_pkt(i == n - 1));
    endtask

    // Reference ordering: whole jobs leave one at a time; strict mode visits
    // requesters in fixed rotation, otherwise the next pending one after p.
    task automatic build_expected(input bit strict, inout int p);
        int  idx [4];
        bit  got;
        int  q;
        seq_pkt_t pk;
        for (int r = 0; r < 4; r++) idx[r] = 0;
        forever begin
            got = 1'b0;
            if (strict) begin
                q = (p + 1) % 4;
                got = idx[q] < srcq[q].size();
            end else begin
                for (int k = 1; k <= 4 && !got; k++) begin
                    q = (p + k) % 4;
                    got = idx[q] < srcq[q].size();
                end
            end
            if (!got) break;
            p = q;
            do begin
                pk = srcq[q][idx[q]];
                expq.push_back('{req: q, p: pk});
                idx[q]++;
            end while (!pk.eoj && idx[q] < srcq[q].size());
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < 4; r++) srcq[r].delete();
        expq.delete();
        xfer_cyc.delete();
        xfer_eoj.delete();
    endtask

    // mode 0: always ready, 1: random backpressure, 2: 5-cycle stall at first output
    task automatic run(input int cycles, input bit until_done, input int mode);
        bit       prev_hold = 1'b0;
        seq_pkt_t prev_pkt = '0;
        logic [1:0] prev_id = '0;
        int       stall_cnt = 0;
        bit       stalled = 1'b0;
        seq_pkt_t h;
        for (int c = 0; c < cycles; c++) begin
            if (until_done && expq.size() == 0) break;
            @(negedge clk);
            cyc++;
            for (int r = 0; r < 4; r++) begin
                a_valid[r] = srcq[r].size() > 0;
                h = a_valid[r] ? srcq[r][0] : rand_pkt(1'b1);
                a_mask[r*MW +: MW]   = h.mask;
                a_ll[r*LLW +: LLW]   = h.ll;
                a_ml[r*MLW +: MLW]   = h.ml;
                a_off[r*OFW +: OFW]  = h.offset;
                a_ovl[r*OVW +: OVW]  = h.overlap;
                a_eoj[r]             = h.eoj;
                a_delim[r]           = h.delim;
            end
            if (mode == 2 && d_ov && !stalled) begin
                stall_cnt = 5;
                stalled   = 1'b1;
            end
            if (mode == 0)      a_ordy = 1'b1;
            else if (mode == 1) a_ordy = ($urandom_range(0, 3) != 0);
            else begin
                a_ordy = (stall_cnt == 0);
                if (stall_cnt > 0) stall_cnt--;
            end
            #1;
            checks++;
            if ($countones(d_irdy) > 1 || (d_ov && !a_ordy && d_irdy != 4'b0)) begin
                errors++;
                $display("FAIL ready_rule cyc=%0d i_ready=%b o_valid=%b o_ready=%b", cyc, d_irdy, d_ov, a_ordy);
            end
            if (prev_hold) begin
                checks++;
                if (!d_ov || d_pkt !== prev_pkt || d_id !== prev_id) begin
                    errors++;
                    $display("FAIL hold_stable cyc=%0d got v=%b id=%0d %h want v=1 id=%0d %h",
                             cyc, d_ov, d_id, d_pkt, prev_id, prev_pkt);
                end
            end
            if (watch_r2) begin
                checks++;
                if (d_irdy[2] !== 1'b0 || d_ov !== 1'b0) begin
                    errors++;
                    $display("FAIL strict_block cyc=%0d i_ready=%b o_valid=%b want i_ready[2]=0 o_valid=0",
                             cyc, d_irdy, d_ov);
                end
            end
            if (d_ov && a_ordy) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out cyc=%0d id=%0d pkt=%h want none", cyc, d_id, d_pkt);
                end else begin
                    if (d_id !== 2'(expq[0].req) || d_pkt !== expq[0].p) begin
                        errors++;
                        $display("FAIL out_pkt cyc=%0d got id=%0d %h want id=%0d %h",
                                 cyc, d_id, d_pkt, expq[0].req, expq[0].p);
                    end
                    void'(expq.pop_front());
                end
                xfer_cyc.push_back(cyc);
                xfer_eoj.push_back(d_pkt.eoj);
            end
            for (int r = 0; r < 4; r++)
                if (a_valid[r] && d_irdy[r]) void'(srcq[r].pop_front());
            prev_hold = d_ov && !a_ordy;
            prev_pkt  = d_pkt;
            prev_id   = d_id;
        end
        if (until_done) begin
            checks++;
            if (expq.size() != 0) begin
                errors++;
                $display("FAIL timeout pending=%0d want 0", expq.size());
            end
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        a_valid = '0; a_eoj = '0; a_delim = '0; a_mask = '0; a_ll = '0;
        a_ml = '0; a_off = '0; a_ovl = '0; a_ordy = 1'b0;
        b_valid = '0; b_eoj = '0; b_delim = '0; b_mask = '0; b_ll = '0;
        b_ml = '0; b_off = '0; b_ovl = '0; b_ordy = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_ov || n_ov || c_ov || s_irdy != 0 || n_irdy != 0 || c_irdy != 0) begin
            errors++;
            $display("FAIL reset_ctrl got v=%b%b%b rdy=%b/%b/%b want all 0",
                     s_ov, n_ov, c_ov, s_irdy, n_irdy, c_irdy);
        end
        checks++;
        if (s_pkt !== '0 || n_pkt !== '0 || c_pkt !== '0 || s_id !== 0 || n_id !== 0 || c_id !== 0) begin
            errors++;
            $display("FAIL reset_payload got %h id=%0d want 0 id=0", s_pkt, s_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_strict_order();
        int p = 3;
        sel = 1'b0;
        do_reset();
        for (int r = 0; r < 4; r++) add_job(r, 2);
        build_expected(1'b1, p);
        run(100, 1'b1, 0);
        checks++;
        if (xfer_cyc.size() != 8) begin
            errors++;
            $display("FAIL strict_count got %0d want 8", xfer_cyc.size());
        end
        for (int i = 1; i < xfer_cyc.size(); i++) begin
            checks++;
            if (xfer_cyc[i] - xfer_cyc[i-1] != (xfer_eoj[i-1] ? 2 : 1)) begin
                errors++;
                $display("FAIL bubble i=%0d gap got %0d want %0d", i,
                         xfer_cyc[i] - xfer_cyc[i-1], xfer_eoj[i-1] ? 2 : 1);
            end
        end
    endtask

    task automatic test_strict_block();
        int p = 3;
        sel = 1'b0;
        do_reset();
        add_job(2, 2);
        build_expected(1'b1, p);
        watch_r2 = 1'b1;
        run(10, 1'b0, 0);
        watch_r2 = 1'b0;
        expq.delete();
        p = 3;
        add_job(0, 3);
        add_job(1, 1);
        build_expected(1'b1, p);
        run(100, 1'b1, 0);
    endtask

    task automatic test_nonstrict();
        int p = 3;
        sel = 1'b1;
        do_reset();
        add_job(0, 1);
        add_job(1, 2);
        add_job(3, 2);
        build_expected(1'b0, p);
        run(100, 1'b1, 0);
        run(4, 1'b0, 0);
        add_job(0, 2);
        build_expected(1'b0, p);
        run(100, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        int p = 3;
        sel = 1'b0;
        do_reset();
        add_job(0, 4);
        add_job(1, 2);
        build_expected(1'b1, p);
        run(100, 1'b1, 2);
    endtask

    task automatic test_random();
        int p;
        for (int t = 0; t < 2; t++) begin
            sel = t[0];
            p = 3;
            do_reset();
            for (int r = 0; r < 4; r++)
                for (int j = 0; j < (t == 0 ? 3 : int'($urandom_range(0, 3))); j++)
                    add_job(r, $urandom_range(1, 4));
            build_expected(t == 0, p);
            run(3000, 1'b1, 1);
        end
    endtask

    task automatic test_reset_midjob();
        int p = 3;
        sel = 1'b0;
        do_reset();
        add_job(0, 4);
        build_expected(1'b1, p);
        run(4, 1'b0, 2);
        checks++;
        if (d_ov !== 1'b1) begin
            errors++;
            $display("FAIL midjob_valid got %b want 1", d_ov);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (d_ov !== 1'b0 || d_pkt !== '0 || d_id !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b id=%0d %h want v=0 id=0 0", d_ov, d_id, d_pkt);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        p = 3;
        add_job(1, 1);
        add_job(0, 2);
        build_expected(1'b1, p);
        run(100, 1'b1, 0);
    endtask

    task automatic test_three_req();
        int k = 0;
        do_reset();
        b_valid = 3'b111;
        b_eoj   = 3'b111;
        b_ordy  = 1'b1;
        for (int r = 0; r < 3; r++) b_ll[r*LLW +: LLW] = LLW'(r + 1);
        for (int c = 0; c < 60 && k < 7; c++) begin
            @(negedge clk);
            #1;
            if (c_ov) begin
                checks++;
                if (c_id !== 2'(k % 3) || c_ll !== LLW'(k % 3 + 1)) begin
                    errors++;
                    $display("FAIL three_req k=%0d got id=%0d ll=%h want id=%0d ll=%0d",
                             k, c_id, c_ll, k % 3, k % 3 + 1);
                end
                k++;
            end
        end
        checks++;
        if (k != 7) begin
            errors++;
            $display("FAIL three_req_timeout got %0d jobs want 7", k);
        end
        b_valid = '0;
    endtask

    initial begin
        test_reset();
        test_strict_order();
        test_strict_block();
        test_nonstrict();
        test_backpressure();
        test_random();
        test_reset_midjob();
        test_three_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_packet_arbiter.md
# seq_packet_arbiter

Job-granular arbiter that shares one downstream sequence-packet consumer (the sequence encoder / output writer) among `NUM_REQ` sequence packers, one per match engine. A grant, once given, stays locked to one requester until that requester's end-of-job packet (`eoj`) is accepted, so packets from different jobs never interleave. In strict mode, grants rotate in fixed requester order so jobs leave in the same order the job dispatcher issued them. Output is a single registered stage carrying the packet and the id of its source.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting packers, ≥2, any value (non-power-of-two allowed).
- `STRICT_ORDER`, 1: 1 = grant pointer advances by exactly one per job; 0 = work-conserving round-robin among valid requesters.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_valid` in NUM_REQ: per-requester packet valid.
- `i_mask` in NUM_REQ*`SEQ_PACKET_SIZE`: per-requester slot mask; requester r occupies slice r.
- `i_ll` in NUM_REQ*`SEQ_PACKET_SIZE`*`SEQ_LL_BITS`: literal lengths.
- `i_ml` in NUM_REQ*`SEQ_PACKET_SIZE`*`SEQ_ML_BITS`: match lengths.
- `i_offset` in NUM_REQ*`SEQ_PACKET_SIZE`*`SEQ_OFFSET_BITS`: offsets.
- `i_overlap` in NUM_REQ*`SEQ_ML_BITS`: overlap length.
- `i_eoj` in NUM_REQ: last packet of a job.
- `i_delim` in NUM_REQ: delimiter flag.
- `i_ready` out NUM_REQ: per-requester accept.
- `o_valid`, `o_mask`, `o_ll`, `o_ml`, `o_offset`, `o_overlap`, `o_eoj`, `o_delim` out: single-packet versions of the above, same per-packet widths.
- `o_req_id` out $clog2(NUM_REQ): source requester of the current output packet.
- `o_ready` in 1: downstream accept.

## Operation
- State machine: `S_ARB`, `S_PASS`. Registers: `state`, `grant` (id), `ptr` (last-served id), output stage.
- Reset (async): `state=S_ARB`; `ptr=NUM_REQ-1`, so the first grant is requester 0; `grant=0`; `o_valid=0`; all output payload registers 0, `o_req_id=0`.
- `S_ARB`, STRICT_ORDER=1: `grant <= (ptr+1) mod NUM_REQ` unconditionally; go to `S_PASS`.
- `S_ARB`, STRICT_ORDER=0: scan `ptr+1, ptr+2, …` (wrapping) for the first set `i_valid`; grant it and go to `S_PASS`. If none is valid, stay in `S_ARB`.
- `S_PASS`: `i_ready[grant] = !o_valid || o_ready`. All other `i_ready` bits are 0. `i_ready` is all-zero in `S_ARB`.
- Accept (`i_valid[grant] && i_ready[grant]`): load the output stage with the granted slice and `o_req_id=grant`; set `o_valid=1`.
- If the accepted packet has `eoj=1`: `ptr <= grant`, `state <= S_ARB`.
- Output drain: `o_valid && o_ready` with no same-cycle accept clears `o_valid`. With a same-cycle accept, `o_valid` stays 1 and the payload is replaced.
- Payload passes through unmodified, including all-zero masks and `delim`. `delim` does not release the grant; only `eoj` does.
- Pointer wrap: `(ptr+1) mod NUM_REQ` uses an explicit compare against `NUM_REQ-1`, not a bit-width overflow.

## Timing
- Latency: packet accepted in cycle t → presented on `o_*` in cycle t+1.
- Throughput: one packet/cycle within a job. There is one `S_ARB` bubble cycle per job boundary.
- No combinational path from `i_valid` to `i_ready`. `o_ready` → `i_ready` is combinational, through one AND.
- Output payload holds stable while `o_valid && !o_ready`.
- A strict-mode grant to an idle requester blocks the others indefinitely. This is intended: ordering takes priority.

## Structure
- Shared package / `parameters.vh`: `SEQ_PACKET_SIZE`, `SEQ_*_BITS`. Add `SEQ_ARB_NUM_REQ`, used as the default source for `NUM_REQ`.
- One natural sub-module: `rr_pick`, a combinational rotating first-one finder (valid vector, pointer → id, found). It is used only when STRICT_ORDER=0.
- Per-requester slice selection is a generate-mux indexed by `grant`.

## Test plan
- Strict, NUM_REQ=4: each requester sends a 2-packet job (second packet `eoj`), all valid at once → output order r0,r0,r1,r1,r2,r2,r3,r3. `o_req_id` matches. Exactly one bubble cycle between jobs.
- Strict: only r2 is valid while the grant is on r0 → no output and `i_ready[2]=0` until r0 and then r1 finish their jobs.
- Non-strict: r1 and r3 valid, `ptr=0` → r1 is served first. After r1's `eoj`, r3 is served. Then, with r0 valid, r0 is served: the pointer wraps 3→0.
- Backpressure: hold `o_ready=0` for 5 cycles mid-job → the first packet is held stable, `i_ready[grant]=0`, and nothing is lost or duplicated when released.
- NUM_REQ=3: 7 single-packet jobs → grants 0,1,2,0,1,2,0.
- Assert `rst_n` low mid-job with `o_valid=1` → outputs clear immediately, asynchronously. After release, the first grant goes to r0.
